regfile_read: RTL and testbench
===============================

# regfile_read

Register file for the pipelined CPU, owning the read side of the register interface. It holds 32 general registers and accepts writeback writes gated by RegWrite. It presents two operands to the execute stage through a registered read stage with same-cycle write bypass, stall hold and flush. It sits between the decode logic (read addresses) and the writeback stage (write port).

## Interface
- NREG, 32, number of registers; address width is log2(NREG) = 5
- DW, 32, data width
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- RegWrite  input  1  writeback write enable
- waddr  input  5  writeback register number
- wdat  input  32  writeback data
- in_valid  input  1  decode presents a valid instruction this cycle
- raddr_a  input  5  operand A register number
- raddr_b  input  5  operand B register number
- stall  input  1  hold the read stage; do not accept new addresses
- flush  input  1  kill the read-stage contents
- out_valid  output  1  odat_a/odat_b carry a live operand pair
- odat_a  output  32  operand A, registered
- odat_b  output  32  operand B, registered
- oaddr_a  output  5  register number behind odat_a, used by the hazard logic
- oaddr_b  output  5  register number behind odat_b

## Operation
- Storage: NREG x DW array. Register 0 reads as 0 at all times, and writes to it are discarded.
- Write: at posedge, if RegWrite=1 and waddr!=0, then mem[waddr] <= wdat.
- Read stage: a register set {out_valid, oaddr_a, oaddr_b, odat_a, odat_b} is updated every posedge. The next state is chosen by priority:
  - flush=1: out_valid<=0, odat_a/odat_b<=0, oaddr_a/oaddr_b<=0.
  - stall=1 (no flush): out_valid, oaddr_a and oaddr_b hold. odat_a and odat_b reload from the held oaddr_a/oaddr_b, so a write landing during the stall is picked up.
  - otherwise: out_valid<=in_valid, oaddr_x<=raddr_x, odat_x<=read(raddr_x).
- read(addr), where addr is the selected address for that port:
  - 0 if addr=0;
  - else wdat if RegWrite=1 and waddr=addr (bypass, same-cycle write wins);
  - else mem[addr].
- Both ports are independent. raddr_a=raddr_b is legal, and both return identical data.
- Reset (async, rst=1): every mem entry <=0, out_valid<=0, odat_a/odat_b<=0, oaddr_a/oaddr_b<=0. Reset overrides RegWrite, stall and flush. A write pending at reset assertion is lost.

## Timing
- Read latency is 1 cycle. Addresses presented before posedge N appear on the outputs after posedge N.
- Write-to-read: a write at posedge N is visible to a read issued in the same cycle via bypass. It is therefore seen at the outputs after posedge N, with no extra delay.
- Stall:
  - The outputs keep the same address and valid for as long as stall is high.
  - Data may change only if the held register is written.
  - The first cycle after stall drops, new raddr values are sampled.
- Flush and stall together: flush wins. out_valid=0 after that edge.
- in_valid=0 without stall still loads the addresses and data. out_valid=0 marks them dead.
- No combinational path exists from inputs to outputs. All outputs are flop outputs.

## Test plan
- Reset: pulse rst mid-cycle after writes. All outputs are 0 immediately (async), and a subsequent read of r5 returns 0.
- Write then read: write r3=0xDEADBEEF at edge 1. Read r3 on port A at edge 2, so odat_a=0xDEADBEEF and oaddr_a=3.
- Bypass: in the same cycle, RegWrite with waddr=7, wdat=0x12345678 and raddr_a=raddr_b=7. After the edge, odat_a=odat_b=0x12345678.
- r0 guard: write r0=0xFFFFFFFF with raddr_b=0 in the same cycle. odat_b=0, and a later read of r0 also returns 0.
- Stall tracking: read r9 (=1) and assert stall for 3 cycles. Write r9=2 during the stall. odat_a becomes 2 one edge after the write, with oaddr_a=9 and out_valid unchanged throughout.
- Flush priority: with stall=1 and flush=1 together, the next edge gives out_valid=0, odat_a=odat_b=0. The register contents are unchanged, checked by reading them back afterwards.

Source files
------------

// File: rtl/regfile_read.sv
// regfile_read: 32-entry register file with a registered dual read stage, write bypass, stall hold and flush
module regfile_read #(
  parameter int NREG = 32,
  parameter int DW = 32,
  parameter int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegWrite,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdat,
  input  logic          in_valid,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  input  logic          stall,
  input  logic          flush,
  output logic          out_valid,
  output logic [DW-1:0] odat_a,
  output logic [DW-1:0] odat_b,
  output logic [AW-1:0] oaddr_a,
  output logic [AW-1:0] oaddr_b
);
  logic [DW-1:0] mem [NREG];
  logic [AW-1:0] sel_a, sel_b;
  logic [DW-1:0] rd_a, rd_b;
  // A stalled stage re-reads its held address so writes landing mid-stall are picked up
  always_comb begin
    sel_a = stall ? oaddr_a : raddr_a;
    sel_b = stall ? oaddr_b : raddr_b;
    rd_a = (sel_a == '0) ? '0 : (RegWrite && waddr == sel_a) ? wdat : mem[sel_a];
    rd_b = (sel_b == '0) ? '0 : (RegWrite && waddr == sel_b) ? wdat : mem[sel_b];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      out_valid <= 1'b0;
      oaddr_a <= '0;
      oaddr_b <= '0;
      odat_a <= '0;
      odat_b <= '0;
    end else begin
      if (RegWrite && waddr != '0) mem[waddr] <= wdat;
      out_valid <= flush ? 1'b0 : stall ? out_valid : in_valid;
      oaddr_a <= flush ? '0 : sel_a;
      oaddr_b <= flush ? '0 : sel_b;
      odat_a <= flush ? '0 : rd_a;
      odat_b <= flush ? '0 : rd_b;
    end
  end
endmodule

// File: tb/tb_regfile_read.sv
// tb_regfile_read: randomized and directed checks of regfile_read against an array-based reference model
module tb_regfile_read;
  logic clk = 0, rst = 1;
  logic RegWrite = 0, in_valid = 0, stall = 0, flush = 0;
  logic [4:0] waddr = 0, raddr_a = 0, raddr_b = 0;
  logic [31:0] wdat = 0;
  logic out_valid;
  logic [31:0] odat_a, odat_b;
  logic [4:0] oaddr_a, oaddr_b;
  int total = 0, bad = 0;

  logic [31:0] m_mem [32];
  logic e_valid;
  logic [4:0] e_aa, e_ab;
  logic [31:0] e_da, e_db;

  regfile_read dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .waddr(waddr), .wdat(wdat),
    .in_valid(in_valid), .raddr_a(raddr_a), .raddr_b(raddr_b), .stall(stall), .flush(flush),
    .out_valid(out_valid), .odat_a(odat_a), .odat_b(odat_b), .oaddr_a(oaddr_a), .oaddr_b(oaddr_b)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [4:0] a);
    if (a == 0) return 0;
    if (RegWrite && waddr == a) return wdat;
    return m_mem[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    e_valid = 0; e_aa = 0; e_ab = 0; e_da = 0; e_db = 0;
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic iv, input logic [4:0] ra, input logic [4:0] rb,
                        input logic st, input logic fl);
    RegWrite = we; waddr = wa; wdat = wd; in_valid = iv;
    raddr_a = ra; raddr_b = rb; stall = st; flush = fl;
  endtask

  // Advance one edge, update the model from the inputs seen at that edge, return at negedge
  task automatic cycle();
    @(posedge clk);
    if (flush) begin
      e_valid = 0; e_aa = 0; e_ab = 0; e_da = 0; e_db = 0;
    end else if (stall) begin
      e_da = rd(e_aa); e_db = rd(e_ab);
    end else begin
      e_valid = in_valid; e_aa = raddr_a; e_ab = raddr_b;
      e_da = rd(raddr_a); e_db = rd(raddr_b);
    end
    if (RegWrite && waddr != 0) m_mem[waddr] = wdat;
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_in(1, 5, 32'hA5A5_0005, 1, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 1, 5, 5, 0, 0); cycle();
    total++;
    if (odat_a !== 32'hA5A5_0005) begin bad++; $display("FAIL pre_reset_read odat_a=%h want=%h", odat_a, 32'hA5A5_0005); end
    set_in(1, 6, 32'h1111_2222, 1, 5, 5, 0, 0);
    #2 rst = 1;
    #1;
    total++;
    if ({out_valid, oaddr_a, oaddr_b, odat_a, odat_b} !== '0) begin
      bad++; $display("FAIL async_reset got v=%b aa=%0d ab=%0d da=%h db=%h want all zero", out_valid, oaddr_a, oaddr_b, odat_a, odat_b);
    end
    model_reset();
    @(negedge clk) rst = 0;
    set_in(0, 0, 0, 1, 5, 6, 0, 0); cycle();
    total++;
    if (odat_a !== 0 || odat_b !== 0 || out_valid !== 1) begin
      bad++; $display("FAIL reset_cleared_mem da=%h db=%h v=%b want 0 0 1", odat_a, odat_b, out_valid);
    end
  endtask

  task automatic test_write_read();
    set_in(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 1, 3, 0, 0, 0); cycle();
    total++;
    if (odat_a !== 32'hDEADBEEF || oaddr_a !== 3 || out_valid !== 1) begin
      bad++; $display("FAIL write_read da=%h aa=%0d v=%b want deadbeef 3 1", odat_a, oaddr_a, out_valid);
    end
  endtask

  task automatic test_bypass();
    set_in(1, 7, 32'h12345678, 1, 7, 7, 0, 0); cycle();
    total++;
    if (odat_a !== 32'h12345678 || odat_b !== 32'h12345678) begin
      bad++; $display("FAIL bypass da=%h db=%h want 12345678", odat_a, odat_b);
    end
  endtask

  task automatic test_r0();
    set_in(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0); cycle();
    total++;
    if (odat_b !== 0) begin bad++; $display("FAIL r0_bypass db=%h want 0", odat_b); end
    set_in(0, 0, 0, 1, 0, 0, 0, 0); cycle();
    total++;
    if (odat_a !== 0 || odat_b !== 0) begin bad++; $display("FAIL r0_read da=%h db=%h want 0", odat_a, odat_b); end
  endtask

  task automatic test_stall();
    logic [31:0] want [3] = '{32'h1, 32'h2, 32'h2};
    set_in(1, 9, 32'h1, 0, 0, 0, 0, 0); cycle();
    set_in(0, 0, 0, 1, 9, 3, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(i == 1, 9, 32'h2, 0, 20, 21, 1, 0); cycle();
      total++;
      if (odat_a !== want[i] || oaddr_a !== 9 || oaddr_b !== 3 || out_valid !== 1 || odat_b !== 32'hDEADBEEF) begin
        bad++; $display("FAIL stall_%0d da=%h aa=%0d ab=%0d v=%b db=%h want %h 9 3 1 deadbeef", i, odat_a, oaddr_a, oaddr_b, out_valid, odat_b, want[i]);
      end
    end
    set_in(0, 0, 0, 1, 7, 9, 0, 0); cycle();
    total++;
    if (oaddr_a !== 7 || odat_a !== 32'h12345678 || odat_b !== 32'h2) begin
      bad++; $display("FAIL stall_release aa=%0d da=%h db=%h want 7 12345678 2", oaddr_a, odat_a, odat_b);
    end
  endtask

  task automatic test_flush();
    set_in(0, 0, 0, 1, 3, 9, 1, 1); cycle();
    total++;
    if ({out_valid, oaddr_a, oaddr_b, odat_a, odat_b} !== '0) begin
      bad++; $display("FAIL flush v=%b aa=%0d ab=%0d da=%h db=%h want all zero", out_valid, oaddr_a, oaddr_b, odat_a, odat_b);
    end
    set_in(0, 0, 0, 1, 3, 9, 0, 0); cycle();
    total++;
    if (odat_a !== 32'hDEADBEEF || odat_b !== 32'h2 || out_valid !== 1) begin
      bad++; $display("FAIL flush_keeps_mem da=%h db=%h v=%b want deadbeef 2 1", odat_a, odat_b, out_valid);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(0, 1), 5'($urandom), $urandom, $urandom_range(0, 1),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      cycle();
      total++;
      if ({out_valid, oaddr_a, oaddr_b, odat_a, odat_b} !== {e_valid, e_aa, e_ab, e_da, e_db}) begin
        bad++; $display("FAIL random_%0d got v=%b aa=%0d ab=%0d da=%h db=%h want v=%b aa=%0d ab=%0d da=%h db=%h",
                        n, out_valid, oaddr_a, oaddr_b, odat_a, odat_b, e_valid, e_aa, e_ab, e_da, e_db);
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_stall();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
